// File: rtl/apb_uart_pkg.sv
// apb_uart_pkg: register map, bit positions and FSM state types shared by the UART peripheral
package apb_uart_pkg;
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_DIV    = 3'd3;
    localparam logic [2:0] REG_IRQ_EN = 3'd4;
    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_EMPTY  = 2;
    localparam int ST_RX_FULL   = 3;
    localparam int ST_TX_BUSY   = 4;
    localparam int ST_RX_OVR    = 5;
    localparam int ST_FRAME_ERR = 6;
    localparam int CTRL_TX_EN = 0;
    localparam int CTRL_RX_EN = 1;
    localparam int IRQ_RX  = 0;
    localparam int IRQ_TX  = 1;
    localparam int IRQ_ERR = 2;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/apb_uart_periph_if.sv
// apb_uart_if: APB3 bus bundle
//   master drives PADDR/PWDATA/PWRITE/PSEL/PENABLE, slave returns PRDATA/PREADY/PSLVERR
interface apb_uart_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
) ();
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [APB_DATA_WIDTH-1:0] PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [APB_DATA_WIDTH-1:0] PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;
    modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PRDATA, PREADY, PSLVERR);
    modport slave (input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous count-based FIFO
//   clk/rst_n: clock, async active-low reset
//   push/wdata: write (ignored when full), pop: read (ignored when empty)
//   rdata: head entry, full/empty: occupancy flags
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_fifo DEPTH must be a power of two >= 2");
    end
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign rdata = mem_q[rd_ptr_q];
    // a push into a full FIFO is rejected even if a pop frees a slot this cycle
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/apb_uart_periph.sv
// apb_uart_periph: APB3 slave 8N1 UART with TX/RX byte FIFOs, baud divisor and level interrupt
//   CLK/RSTN: clock, async active-low reset
//   apb: APB3 slave port (zero wait states)
//   rx_i: serial input (asynchronous), tx_o: serial output (idle high), event_o: interrupt
module apb_uart_periph
    import apb_uart_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RSTN,
    apb_uart_if.slave  apb,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       event_o
);
    if (APB_ADDR_WIDTH < 5 || APB_DATA_WIDTH < 16) begin : g_width_check
        $error("apb_uart_periph needs APB_ADDR_WIDTH >= 5 and APB_DATA_WIDTH >= 16");
    end
    logic [2:0] idx;
    logic access, wr, rd, bad_addr;
    assign idx = apb.PADDR[4:2];
    assign access = apb.PSEL & apb.PENABLE;
    assign wr = access & apb.PWRITE;
    assign rd = access & ~apb.PWRITE;
    assign bad_addr = idx > REG_IRQ_EN;
    logic [1:0] ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d;
    logic [2:0] irq_en_q, irq_en_d;
    logic rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d;
    logic rx_ovr_set, frame_set;
    logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] tx_rdata, rx_rdata;
    assign tx_push = wr & (idx == REG_DATA);
    assign rx_pop = rd & (idx == REG_DATA);
    tx_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic tx_q, tx_d, tx_tick, tx_busy;
    rx_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic rx_s1_q, rx_s2_q, rx_prev_q;
    logic rx_tick, rx_half, rx_fall;
    logic [16:0] rx_half_cnt;
    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(CLK), .rst_n(RSTN), .push(tx_push), .wdata(apb.PWDATA[7:0]), .pop(tx_pop),
        .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
    );
    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(CLK), .rst_n(RSTN), .push(rx_push), .wdata(rx_shift_q), .pop(rx_pop),
        .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
    );
    // Each bit latches its own period so a DIV write only lands on the next bit boundary.
    assign tx_tick = tx_cnt_q == tx_div_q;
    assign tx_busy = tx_state_q != TX_IDLE;
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d = tx_cnt_q + 16'd1;
        tx_div_d = tx_div_q;
        tx_bit_d = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d = tx_q;
        tx_pop = 1'b0;
        if (tx_tick || tx_state_q == TX_IDLE) begin
            tx_cnt_d = '0;
            tx_div_d = div_q;
        end
        case (tx_state_q)
            TX_IDLE: if (ctrl_q[CTRL_TX_EN] && !tx_empty) begin
                tx_pop = 1'b1;
                tx_shift_d = tx_rdata;
                tx_d = 1'b0;
                tx_state_d = TX_START;
            end
            TX_START: if (tx_tick) begin
                tx_d = tx_shift_q[0];
                tx_bit_d = '0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_tick) begin
                tx_bit_d = tx_bit_q + 3'd1;
                tx_shift_d = tx_shift_q >> 1;
                tx_d = tx_bit_q == 3'd7 ? 1'b1 : tx_shift_q[1];
                tx_state_d = tx_bit_q == 3'd7 ? TX_STOP : TX_DATA;
            end
            TX_STOP: if (tx_tick) tx_state_d = TX_IDLE;
        endcase
    end
    // Start bit is re-checked (DIV+1)/2 clocks after the edge, landing mid-bit.
    assign rx_fall = rx_prev_q & ~rx_s2_q;
    assign rx_tick = rx_cnt_q == rx_div_q;
    assign rx_half_cnt = ({1'b0, rx_div_q} + 17'd1) >> 1;
    assign rx_half = {1'b0, rx_cnt_q} == rx_half_cnt - 17'd1;
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d = rx_cnt_q + 16'd1;
        rx_div_d = rx_div_q;
        rx_bit_d = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push = 1'b0;
        rx_ovr_set = 1'b0;
        frame_set = 1'b0;
        if (rx_tick || rx_state_q == RX_IDLE) begin
            rx_cnt_d = '0;
            rx_div_d = div_q;
        end
        case (rx_state_q)
            RX_IDLE: if (ctrl_q[CTRL_RX_EN] && rx_fall) rx_state_d = RX_START;
            RX_START: if (rx_half) begin
                rx_cnt_d = '0;
                rx_div_d = div_q;
                rx_bit_d = '0;
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                rx_state_d = rx_bit_q == 3'd7 ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (rx_tick) begin
                rx_push = rx_s2_q & ~rx_full;
                rx_ovr_set = rx_s2_q & rx_full;
                frame_set = ~rx_s2_q;
                rx_state_d = RX_IDLE;
            end
        endcase
    end
    always_comb begin
        ctrl_d = (wr && idx == REG_CTRL) ? apb.PWDATA[1:0] : ctrl_q;
        div_d = (wr && idx == REG_DIV) ? apb.PWDATA[15:0] : div_q;
        irq_en_d = (wr && idx == REG_IRQ_EN) ? apb.PWDATA[2:0] : irq_en_q;
        // a new error in the same cycle as its clear wins
        rx_ovr_d = (rx_ovr_q & ~(wr && idx == REG_STATUS && apb.PWDATA[ST_RX_OVR])) | rx_ovr_set;
        frame_err_d = (frame_err_q & ~(wr && idx == REG_STATUS && apb.PWDATA[ST_FRAME_ERR])) | frame_set;
    end
    logic [APB_DATA_WIDTH-1:0] rdata;
    always_comb begin
        rdata = '0;
        case (idx)
            REG_DATA: rdata[7:0] = rx_empty ? 8'd0 : rx_rdata;
            REG_STATUS: rdata[6:0] = {frame_err_q, rx_ovr_q, tx_busy, rx_full, rx_empty, tx_empty, tx_full};
            REG_CTRL: rdata[1:0] = ctrl_q;
            REG_DIV: rdata[15:0] = div_q;
            REG_IRQ_EN: rdata[2:0] = irq_en_q;
            default: rdata = '0;
        endcase
    end
    assign apb.PRDATA = rd ? rdata : '0;
    assign apb.PREADY = 1'b1;
    assign apb.PSLVERR = access & (bad_addr | (apb.PWRITE & (idx == REG_DATA) & tx_full));
    assign tx_o = tx_q;
    assign event_o = (irq_en_q[IRQ_RX] & ~rx_empty) | (irq_en_q[IRQ_TX] & tx_empty & ~tx_busy)
                   | (irq_en_q[IRQ_ERR] & (rx_ovr_q | frame_err_q));
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ctrl_q <= '0;
            div_q <= '0;
            irq_en_q <= '0;
            rx_ovr_q <= 1'b0;
            frame_err_q <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q <= '0;
            tx_div_q <= '0;
            tx_bit_q <= '0;
            tx_shift_q <= '0;
            tx_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q <= '0;
            rx_div_q <= '0;
            rx_bit_q <= '0;
            rx_shift_q <= '0;
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            ctrl_q <= ctrl_d;
            div_q <= div_d;
            irq_en_q <= irq_en_d;
            rx_ovr_q <= rx_ovr_d;
            frame_err_q <= frame_err_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q <= tx_cnt_d;
            tx_div_q <= tx_div_d;
            tx_bit_q <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q <= rx_cnt_d;
            rx_div_q <= rx_div_d;
            rx_bit_q <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end
endmodule

// File: tb/tb_apb_uart_periph.sv
// tb_apb_uart_periph: randomized self-checking bench for apb_uart_periph against a frame-level model
module tb_apb_uart_periph;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_drv = 1'b1;
    logic lb = 1'b0;
    logic rx_i, tx_o, event_o;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    apb_uart_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) apb ();
    assign rx_i = lb ? tx_o : rx_drv;
    apb_uart_periph #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
        .CLK(clk), .RSTN(rst_n), .apb(apb), .rx_i(rx_i), .tx_o(tx_o), .event_o(event_o)
    );
    localparam logic [31:0] A_DATA = 32'h00, A_STAT = 32'h04, A_CTRL = 32'h08, A_DIV = 32'h0C, A_IRQ = 32'h10;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] rdata, output logic err);
        @(negedge clk);
        apb.PADDR = addr;
        apb.PWDATA = data;
        apb.PWRITE = wr;
        apb.PSEL = 1'b1;
        apb.PENABLE = 1'b0;
        @(negedge clk);
        apb.PENABLE = 1'b1;
        #1;
        rdata = apb.PRDATA;
        err = apb.PSLVERR;
        @(negedge clk);
        apb.PSEL = 1'b0;
        apb.PENABLE = 1'b0;
    endtask
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r;
        logic e;
        apb_xfer(1'b1, addr, data, r, e);
    endtask
    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic e;
        apb_xfer(1'b0, addr, 32'h0, r, e);
        check(tag, r, exp);
    endtask
    function automatic logic frame_bit(input logic [7:0] b, input int i, input logic stop);
        return i == 0 ? 1'b0 : (i == 9 ? stop : b[i-1]);
    endfunction
    task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
        for (int i = 0; i < 10; i++) begin
            rx_drv = frame_bit(b, i, stop);
            repeat (d + 1) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] r;
        logic e;
        logic [7:0] q[$];
        apb.PADDR = '0;
        apb.PWDATA = '0;
        apb.PWRITE = 1'b0;
        apb.PSEL = 1'b0;
        apb.PENABLE = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_o", 32'(tx_o), 32'd1);
        check("rst_event", 32'(event_o), 32'd0);
        check("rst_pready", 32'(apb.PREADY), 32'd1);
        check("rst_prdata", apb.PRDATA, 32'd0);
        check("rst_pslverr", 32'(apb.PSLVERR), 32'd0);
        rst_n = 1'b1;
        rd_chk("rst_status", A_STAT, 32'h06);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_div", A_DIV, 32'h0);
        rd_chk("rst_irq", A_IRQ, 32'h0);
        // transmitter: bit-exact waveform with random bytes and divisors
        wr(A_CTRL, 32'h1);
        for (int t = 0; t < 4; t++) begin
            automatic int d = t == 0 ? 3 : int'($urandom_range(3, 6));
            automatic logic [7:0] b = t == 0 ? 8'hA5 : 8'($urandom);
            automatic int len = 10 * (d + 1);
            wr(A_DIV, 32'(d));
            apb_xfer(1'b1, A_DATA, {24'h0, b}, r, e);
            check("tx_wr_err", 32'(e), 32'd0);
            fork
                begin
                    for (int s = 0; s < len; s++) begin
                        @(negedge clk);
                        check($sformatf("tx_bit b=%h s=%0d", b, s), 32'(tx_o), 32'(frame_bit(b, s / (d + 1), 1'b1)));
                    end
                end
                begin
                    logic [31:0] st;
                    logic se;
                    repeat (len - 2) @(negedge clk);
                    apb_xfer(1'b0, A_STAT, 32'h0, st, se);
                    check("tx_busy_end", st & 32'h10, 32'h10);
                end
            join
            rd_chk("tx_done_status", A_STAT, 32'h06);
        end
        // receiver: random bytes at DIV=7
        wr(A_CTRL, 32'h2);
        wr(A_DIV, 32'd7);
        for (int t = 0; t < 4; t++) begin
            automatic logic [7:0] b = t == 0 ? 8'h3C : 8'($urandom);
            send_frame(b, 1'b1, 7);
            rd_chk("rx_status_full", A_STAT, 32'h02);
            rd_chk("rx_data", A_DATA, {24'h0, b});
            rd_chk("rx_status_empty", A_STAT, 32'h06);
        end
        // framing error
        send_frame(8'($urandom), 1'b0, 7);
        rd_chk("ferr_status", A_STAT, 32'h46);
        check("ferr_no_irq", 32'(event_o), 32'd0);
        wr(A_IRQ, 32'h4);
        check("ferr_irq", 32'(event_o), 32'd1);
        wr(A_STAT, 32'h3F);
        rd_chk("ferr_sticky", A_STAT, 32'h46);
        wr(A_STAT, 32'h40);
        rd_chk("ferr_clear", A_STAT, 32'h06);
        check("ferr_irq_clear", 32'(event_o), 32'd0);
        // TX FIFO overflow, then drain through loopback
        wr(A_IRQ, 32'h0);
        wr(A_CTRL, 32'h0);
        wr(A_DIV, 32'd3);
        for (int i = 0; i < 9; i++) begin
            automatic logic [7:0] b = 8'($urandom);
            apb_xfer(1'b1, A_DATA, {24'h0, b}, r, e);
            check($sformatf("txov_err%0d", i), 32'(e), 32'(i == 8));
            if (i < 8) q.push_back(b);
        end
        rd_chk("txov_status", A_STAT, 32'h05);
        lb = 1'b1;
        wr(A_CTRL, 32'h3);
        repeat (400) @(negedge clk);
        rd_chk("lb_status", A_STAT, 32'h0A);
        while (q.size() > 0) rd_chk("lb_data", A_DATA, {24'h0, q.pop_front()});
        rd_chk("lb_status_empty", A_STAT, 32'h06);
        lb = 1'b0;
        // RX overrun
        wr(A_CTRL, 32'h2);
        wr(A_DIV, 32'd7);
        for (int i = 0; i < 9; i++) begin
            automatic logic [7:0] b = 8'($urandom);
            send_frame(b, 1'b1, 7);
            if (i < 8) q.push_back(b);
        end
        rd_chk("rxov_status", A_STAT, 32'h2A);
        while (q.size() > 0) rd_chk("rxov_data", A_DATA, {24'h0, q.pop_front()});
        rd_chk("rxov_status_drained", A_STAT, 32'h26);
        wr(A_STAT, 32'h20);
        rd_chk("rxov_clear", A_STAT, 32'h06);
        // unmapped offsets and empty read
        apb_xfer(1'b0, 32'h14, 32'h0, r, e);
        check("bad_rd_data", r, 32'h0);
        check("bad_rd_err", 32'(e), 32'd1);
        apb_xfer(1'b1, 32'h18, 32'hFFFF_FFFF, r, e);
        check("bad_wr_err", 32'(e), 32'd1);
        apb_xfer(1'b0, A_DATA, 32'h0, r, e);
        check("empty_rd_data", r, 32'h0);
        check("empty_rd_err", 32'(e), 32'd0);
        // interrupt sources
        wr(A_IRQ, 32'h1);
        check("irq_rx_idle", 32'(event_o), 32'd0);
        send_frame(8'h5A, 1'b1, 7);
        check("irq_rx_set", 32'(event_o), 32'd1);
        rd_chk("irq_rx_data", A_DATA, 32'h5A);
        check("irq_rx_clr", 32'(event_o), 32'd0);
        wr(A_IRQ, 32'h2);
        check("irq_tx_set", 32'(event_o), 32'd1);
        wr(A_DATA, 32'h11);
        check("irq_tx_clr", 32'(event_o), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_uart_periph.md
# apb_uart_periph

APB3-slave UART peripheral: 8N1 serial transmitter/receiver with byte FIFOs, a programmable baud divisor and one level interrupt. It sits on the APB3 peripheral bus, bridged from the Renode co-simulation requester. It drives `tx_o`/`rx_i` toward an external serial line and `event_o` toward the interrupt fabric.

## Interface
- `APB_ADDR_WIDTH`, 32: `PADDR` width; only `PADDR[4:2]` decoded.
- `APB_DATA_WIDTH`, 32: `PWDATA`/`PRDATA` width.
- `FIFO_DEPTH`, 8: TX and RX FIFO depth in bytes (power of two, ≥2).
- `CLK` in 1: single clock, all logic rising-edge.
- `RSTN` in 1: reset, asynchronous, active-low.
- `PADDR` in `APB_ADDR_WIDTH`: register address.
- `PWDATA` in `APB_DATA_WIDTH`: write data.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PSEL` in 1: slave select.
- `PENABLE` in 1: access phase.
- `PRDATA` out `APB_DATA_WIDTH`: read data.
- `PREADY` out 1: transfer ready.
- `PSLVERR` out 1: transfer error.
- `rx_i` in 1: serial input, asynchronous to `CLK`.
- `tx_o` out 1: serial output, idle high.
- `event_o` out 1: level interrupt.

## Operation
- Register map, word offsets; unused bits read 0:
  - 0x00 DATA.
    - Write pushes `PWDATA[7:0]` to the TX FIFO. If the TX FIFO is full, the byte is dropped and `PSLVERR`=1.
    - Read pops the RX FIFO and returns the byte in [7:0]. If the RX FIFO is empty, read returns 0 with no error.
  - 0x04 STATUS.
    - Bits: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] tx_busy, [5] rx_overrun, [6] frame_err.
    - [5] and [6] are sticky and write-1-to-clear. All other bits are read-only.
  - 0x08 CTRL: [0] tx_en, [1] rx_en.
  - 0x0C DIV: [15:0]. Bit period = DIV+1 clocks. RX requires DIV≥3.
  - 0x10 IRQ_EN: [0] rx_not_empty, [1] tx_empty, [2] error.
  - Any other offset: write ignored, read returns 0, `PSLVERR`=1.
- Framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- Transmitter:
  - States IDLE → START → DATA(8) → STOP → IDLE.
  - Leaves IDLE when tx_en=1 and the TX FIFO is not empty, popping one byte.
  - Clearing tx_en mid-frame finishes the current frame, then stalls.
- Receiver:
  - `rx_i` passes through a 2-flop synchronizer.
  - States IDLE → START → DATA(8) → STOP → IDLE.
  - A falling edge in IDLE with rx_en=1 starts a frame.
  - START re-samples after (DIV+1)/2 clocks. If the line is high, it is a false start and the receiver returns to IDLE.
  - Data bits and the stop bit are sampled mid-bit.
  - Stop bit = 0: set frame_err and discard the byte.
  - RX FIFO full at stop: set rx_overrun and drop the byte.
- Interrupt: `event_o` = (IRQ_EN[0] & !rx_empty) | (IRQ_EN[1] & tx_empty & !tx_busy) | (IRQ_EN[2] & (rx_overrun | frame_err)).
- FIFO: push and pop in the same cycle both take effect. A push while full is rejected even if a pop occurs in that cycle.

## Timing
- Reset values:
  - All registers 0 and FIFOs empty.
  - `tx_o`=1, `PREADY`=1.
  - `PRDATA`=0, `PSLVERR`=0, `event_o`=0.
- APB: zero wait states; `PREADY` is tied to 1.
  - Setup phase (`PSEL`&!`PENABLE`) has no side effects.
  - In the access phase (`PSEL`&`PENABLE`), writes and FIFO pops commit on the rising edge.
  - `PRDATA` and `PSLVERR` are combinational during the access phase and 0 otherwise.
- TX latency: start bit appears on `tx_o` the cycle after the FIFO pop. A frame lasts exactly 10×(DIV+1) clocks.
- RX latency: a byte is pushed into the RX FIFO 2 sync cycles plus one clock after the stop-bit sample point.
- The DIV change takes effect at the next bit boundary.
- Asserting `RSTN` mid-frame aborts the frame immediately and drives `tx_o` high.

## Structure
- Package `apb_uart_pkg`: register offset constants, STATUS/CTRL/IRQ_EN bit-index constants, TX/RX state enums.
- Sub-module `uart_fifo` (synchronous, parameterized width/depth, count-based full/empty), instantiated twice.
- TX and RX FSMs and the APB register decode live inline in the top.

## Test plan
- Reset: check reset values.
  - STATUS reads 0x06 (tx_empty|rx_empty).
  - `tx_o`=1, `event_o`=0.
- DIV=3, CTRL=1, write DATA=0xA5 → `tx_o` shows the 0,1,0,1,0,0,1,0,1,1 pattern (start, data LSB first, stop).
  - Each bit lasts 4 clocks.
  - tx_busy is set during the frame and the frame ends after 40 clocks.
- DIV=7, CTRL=2, drive 0x3C serially on `rx_i` → STATUS[2]=0. DATA reads 0x3C, then STATUS[2]=1.
- Send a frame with stop=0 → frame_err=1 and the RX FIFO stays empty.
  - With IRQ_EN=4, `event_o`=1.
  - Writing STATUS=0x40 clears frame_err and `event_o`.
- Overflow handling:
  - With CTRL=0, write 9 bytes → the 9th write returns `PSLVERR`=1 and tx_full=1.
  - Receive 9 frames with no reads → rx_overrun=1 and 8 bytes are readable.
- Read offset 0x14 → `PRDATA`=0, `PSLVERR`=1.
  - IRQ_EN=1 with the RX FIFO non-empty → `event_o`=1.
